// File: rtl/tm_lif_pkg.sv
// -----------------------------------------------------------------------------
// tm_lif_pkg
// Shared definitions for the time-multiplexed LIF neuron array:
//   - lif_state_e : sweep controller states (idle / update / done)
//   - idx_w()     : index width helper, never returns less than 1 bit
//   - sat_add()   : unsigned add clamped to the largest w-bit value
// -----------------------------------------------------------------------------
package tm_lif_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_DONE   = 2'd2
   } lif_state_e;

   // Bits needed to index n items; a 1-bit field is kept even for n <= 2.
   function automatic int idx_w(input int n);
      if (n > 2) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

   // Unsigned add of two operands; result clamped to 2^w-1 instead of wrapping.
   // The sum is formed one bit wider than the operands so the carry is never lost.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int          w);
      logic [32:0] sum_v;
      logic [32:0] max_v;
      sum_v = {1'b0, a} + {1'b0, b};
      max_v = (33'd1 << w) - 33'd1;
      if (sum_v > max_v) begin
         return max_v[31:0];
      end else begin
         return sum_v[31:0];
      end
   endfunction

endpackage

// File: rtl/tm_lif_array_pe.sv
// -----------------------------------------------------------------------------
// lif_pe
// Purely combinational single-neuron update, shared by every neuron of the
// array through time multiplexing.
// Ports:
//   state      in  current membrane state
//   cur        in  input current for this frame
//   thr        in  firing threshold
//   refr       in  remaining refractory frames
//   next_state out membrane state after this frame
//   next_r     out refractory count after this frame
//   spike      out neuron fired this frame
// -----------------------------------------------------------------------------
module lif_pe
   import tm_lif_pkg::*;
#(
   parameter int STATE_W       = 8,
   parameter int CUR_W         = 8,
   parameter int LEAK_SHIFT    = 1,
   parameter int REFRAC_FRAMES = 2,
   parameter int RW            = 2
) (
   input  logic [STATE_W-1:0] state,
   input  logic [CUR_W-1:0]   cur,
   input  logic [STATE_W-1:0] thr,
   input  logic [RW-1:0]      refr,
   output logic [STATE_W-1:0] next_state,
   output logic [RW-1:0]      next_r,
   output logic               spike
);

   logic [STATE_W-1:0] leaked_s;
   logic [STATE_W-1:0] sum_s;

   assign leaked_s = state >> LEAK_SHIFT;
   assign sum_s    = STATE_W'(sat_add(32'(cur), 32'(leaked_s), STATE_W));

   // Refractory hold takes priority; otherwise integrate, compare and fire.
   always_comb begin
      next_state = '0;
      next_r     = '0;
      spike      = 1'b0;
      if (refr != '0) begin
         next_state = '0;
         next_r     = refr - RW'(1);
         spike      = 1'b0;
      end else if (sum_s >= thr) begin
         next_state = '0;
         next_r     = RW'(REFRAC_FRAMES);
         spike      = 1'b1;
      end else begin
         next_state = sum_s;
         next_r     = '0;
         spike      = 1'b0;
      end
   end

endmodule

// File: rtl/tm_lif_array.sv
// -----------------------------------------------------------------------------
// tm_lif_array
// Time-multiplexed leaky-integrate-and-fire neuron array. A frame is accepted
// on in_valid && in_ready, then one neuron is updated per clock through a
// single lif_pe; the completed spike vector is published for one DONE cycle.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready frame start handshake (ready only while idle)
//   current           per-neuron currents, neuron i at [i*CUR_W +: CUR_W]
//   cfg_we/addr/data  threshold write port, accepted in any state
//   rd_addr/rd_data   registered membrane-state readback (0 if out of range)
//   spike/spike_valid last completed frame's spikes, valid pulses in DONE
//   busy              high while a frame is in progress (UPDATE or DONE)
//   spike_cnt         popcount of spike; present only with TM_LIF_SPIKE_CNT_EN
// Build option: define TM_LIF_SPIKE_CNT_EN to add the spike_cnt output.
// -----------------------------------------------------------------------------
module tm_lif_array
   import tm_lif_pkg::*;
#(
   parameter int NUM_NEURONS   = 8,
   parameter int STATE_W       = 8,
   parameter int CUR_W         = 8,
   parameter int LEAK_SHIFT    = 1,
   parameter int REFRAC_FRAMES = 2,
   parameter int THR_INIT      = 127
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [NUM_NEURONS*CUR_W-1:0]     current,
   input  logic                             cfg_we,
   input  logic [idx_w(NUM_NEURONS)-1:0]    cfg_addr,
   input  logic [STATE_W-1:0]               cfg_data,
   input  logic [idx_w(NUM_NEURONS)-1:0]    rd_addr,
   output logic [STATE_W-1:0]               rd_data,
   output logic [NUM_NEURONS-1:0]           spike,
   output logic                             spike_valid,
   output logic                             busy
`ifdef TM_LIF_SPIKE_CNT_EN
   ,
   output logic [idx_w(NUM_NEURONS+1)-1:0]  spike_cnt
`endif
);

   localparam int IW = idx_w(NUM_NEURONS);
   localparam int RW = idx_w(REFRAC_FRAMES + 1);
   localparam int CW = idx_w(NUM_NEURONS + 1);

   lif_state_e                 fsm_r;
   logic [IW-1:0]              idx_r;
   logic [NUM_NEURONS*CUR_W-1:0] cur_buf_r;
   logic [STATE_W-1:0]         state_r [NUM_NEURONS];
   logic [STATE_W-1:0]         thr_r   [NUM_NEURONS];
   logic [RW-1:0]              refr_r  [NUM_NEURONS];
   logic [NUM_NEURONS-1:0]     shadow_r;
   logic [NUM_NEURONS-1:0]     spike_r;
   logic                       spike_valid_r;
   logic                       in_ready_r;
   logic                       busy_r;
   logic [STATE_W-1:0]         rd_data_r;

   logic [STATE_W-1:0]         pe_state_s;
   logic [CUR_W-1:0]           pe_cur_s;
   logic [STATE_W-1:0]         pe_thr_s;
   logic [RW-1:0]              pe_refr_s;
   logic [STATE_W-1:0]         pe_next_state_s;
   logic [RW-1:0]              pe_next_r_s;
   logic                       pe_spike_s;
   logic [NUM_NEURONS-1:0]     shadow_next_s;
   logic                       accept_s;
   logic                       last_idx_s;
   logic                       cfg_ok_s;
   logic                       rd_ok_s;

   assign accept_s   = in_valid && in_ready_r;
   assign last_idx_s = (idx_r == IW'(NUM_NEURONS - 1));
   // Widened by one bit so the range check stays meaningful for any size.
   assign cfg_ok_s   = ({1'b0, cfg_addr} < (IW+1)'(NUM_NEURONS));
   assign rd_ok_s    = ({1'b0, rd_addr}  < (IW+1)'(NUM_NEURONS));

   // Select the operands of the neuron currently being swept.
   always_comb begin
      pe_state_s = state_r[idx_r];
      pe_cur_s   = cur_buf_r[idx_r*CUR_W +: CUR_W];
      pe_thr_s   = thr_r[idx_r];
      pe_refr_s  = refr_r[idx_r];
   end

   lif_pe #(
      .STATE_W       (STATE_W),
      .CUR_W         (CUR_W),
      .LEAK_SHIFT    (LEAK_SHIFT),
      .REFRAC_FRAMES (REFRAC_FRAMES),
      .RW            (RW)
   ) u_pe (
      .state      (pe_state_s),
      .cur        (pe_cur_s),
      .thr        (pe_thr_s),
      .refr       (pe_refr_s),
      .next_state (pe_next_state_s),
      .next_r     (pe_next_r_s),
      .spike      (pe_spike_s)
   );

   // Shadow vector including the bit being produced this cycle, so the last
   // neuron's result is part of the copy made on entry to DONE.
   always_comb begin
      shadow_next_s        = shadow_r;
      shadow_next_s[idx_r] = pe_spike_s;
   end

   // Sweep controller: handshake, neuron index and spike publication.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_r         <= ST_IDLE;
         idx_r         <= '0;
         cur_buf_r     <= '0;
         shadow_r      <= '0;
         spike_r       <= '0;
         spike_valid_r <= 1'b0;
         in_ready_r    <= 1'b1;
         busy_r        <= 1'b0;
      end else begin
         case (fsm_r)
            ST_IDLE: begin
               spike_valid_r <= 1'b0;
               if (accept_s) begin
                  cur_buf_r  <= current;
                  idx_r      <= '0;
                  shadow_r   <= '0;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  fsm_r      <= ST_UPDATE;
               end
            end
            ST_UPDATE: begin
               shadow_r <= shadow_next_s;
               if (last_idx_s) begin
                  spike_r       <= shadow_next_s;
                  spike_valid_r <= 1'b1;
                  idx_r         <= '0;
                  fsm_r         <= ST_DONE;
               end else begin
                  idx_r <= idx_r + IW'(1);
               end
            end
            ST_DONE: begin
               spike_valid_r <= 1'b0;
               in_ready_r    <= 1'b1;
               busy_r        <= 1'b0;
               fsm_r         <= ST_IDLE;
            end
            default: begin
               spike_valid_r <= 1'b0;
               in_ready_r    <= 1'b1;
               busy_r        <= 1'b0;
               idx_r         <= '0;
               fsm_r         <= ST_IDLE;
            end
         endcase
      end
   end

   // Per-neuron storage: state/refractory written back by the sweep, thresholds
   // by the config port. The sweep reads thr_r before this edge's write lands.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            state_r[i] <= '0;
            refr_r[i]  <= '0;
            thr_r[i]   <= STATE_W'(THR_INIT);
         end
      end else begin
         if (fsm_r == ST_UPDATE) begin
            state_r[idx_r] <= pe_next_state_s;
            refr_r[idx_r]  <= pe_next_r_s;
         end
         if (cfg_we && cfg_ok_s) begin
            thr_r[cfg_addr] <= cfg_data;
         end
      end
   end

   // Registered readback; samples the pre-update value on a colliding edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data_r <= '0;
      end else if (rd_ok_s) begin
         rd_data_r <= state_r[rd_addr];
      end else begin
         rd_data_r <= '0;
      end
   end

`ifdef TM_LIF_SPIKE_CNT_EN
   logic [CW-1:0] cnt_s;
   logic [CW-1:0] spike_cnt_r;

   // Population count of the frame being published.
   always_comb begin
      cnt_s = '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
         cnt_s = cnt_s + CW'(shadow_next_s[i]);
      end
   end

   // Count register, updated together with spike_r.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         spike_cnt_r <= '0;
      end else if ((fsm_r == ST_UPDATE) && last_idx_s) begin
         spike_cnt_r <= cnt_s;
      end
   end

   assign spike_cnt = spike_cnt_r;
`endif

   assign in_ready    = in_ready_r;
   assign busy        = busy_r;
   assign spike       = spike_r;
   assign spike_valid = spike_valid_r;
   assign rd_data     = rd_data_r;

endmodule
